// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline WB stage
// and a long-latency unit (mul/div) result stream. LU results are buffered in
// a small FIFO and drained whenever the pipeline is not writing; if the
// buffer head waits too long, a one-cycle FORCE state stalls the pipeline
// and writes the head unconditionally.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_rd,
  input  logic [XLEN-1:0]            pipe_wdata,
  input  logic                       lu_valid,
  input  logic [4:0]                 lu_rd,
  input  logic [XLEN-1:0]            lu_wdata,
  output logic                       lu_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       stall_req,
  output logic [$clog2(DEPTH):0]     buf_level
);

  localparam int PW = $clog2(DEPTH);          // pointer width
  localparam int CW = PW + 1;                 // occupancy width (0..DEPTH)
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic            pipe_valid;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  // Request qualification and buffer head view.
  always_comb begin
    pipe_valid = pipe_we && (pipe_rd != 5'd0);
    lu_ready   = (count_q < CW'(DEPTH));
    push       = lu_valid && lu_ready;
    head_rd    = mem_rd[rd_ptr_q];
    head_data  = mem_data[rd_ptr_q];
  end

  // Port arbitration, FIFO bookkeeping and next-state selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = '0;

    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (pipe_valid) begin
          wr_en   = 1'b1;
          wr_addr = pipe_rd;
          wr_data = pipe_wdata;
        end
      end
      S_DRAIN: begin
        if (pipe_valid) begin
          // Pipe wins; head is held and accumulates waiting time.
          wr_en   = 1'b1;
          wr_addr = pipe_rd;
          wr_data = pipe_wdata;
          if (wait_q != WW'(STARVE_LIMIT)) wait_d = wait_q + WW'(1);
        end else begin
          pop    = 1'b1;
          wait_d = '0;
          if (head_rd != 5'd0) begin
            wr_en   = 1'b1;
            wr_addr = head_rd;
            wr_data = head_data;
          end
        end
      end
      S_FORCE: begin
        // Pipe request ignored; MEM/WB is held so it retries next cycle.
        pop    = 1'b1;
        wait_d = '0;
        if (head_rd != 5'd0) begin
          wr_en   = 1'b1;
          wr_addr = head_rd;
          wr_data = head_data;
        end
      end
      default: ;
    endcase

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    unique case (state_q)
      S_IDLE:  state_d = push ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (pop)                              state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
        else if (wait_d == WW'(STARVE_LIMIT)) state_d = S_FORCE;
        else                                  state_d = S_DRAIN;
      end
      S_FORCE: state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port outputs; held quiet while reset is asserted.
  always_comb begin
    rf_we     = rstn && wr_en;
    rf_waddr  = rstn ? wr_addr : 5'd0;
    rf_wdata  = rstn ? wr_data : '0;
    stall_req = (state_q == S_FORCE);
    buf_level = count_q;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rstn) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wait_q   <= wait_d;
    end
  end

  // Buffer storage written in push order.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are live.
    if (push) begin
      mem_rd[wr_ptr_q]   <= lu_rd;
      mem_data[wr_ptr_q] <= lu_wdata;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Shares the single register-file write port between the pipeline WB stage and a long-latency unit (LU: mul/div) result stream.

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of LU result buffer entries (power of two, >=2).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the wait cycles before a forced drain (>=1).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- pipe_we  in  1  WB stage RegWrite
- pipe_rd  in  5  WB stage destination
- pipe_wdata  in  XLEN  WB stage selected result
- lu_valid  in  1  LU result valid
- lu_rd  in  5  LU destination
- lu_wdata  in  XLEN  LU result
- lu_ready  out  1  buffer can accept
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- stall_req  out  1  hold MEM/WB and upstream this cycle
- buf_level  out  $clog2(DEPTH)+1  occupied entries

Function
REQ-005 The block SHALL push {lu_rd, lu_wdata} into a FIFO at the clock edge when lu_valid && lu_ready.
REQ-006 lu_ready SHALL equal (registered count < DEPTH); a pop in the same cycle SHALL NOT raise lu_ready when full.
REQ-007 The block SHALL NOT bypass a pushed entry; its earliest write SHALL be the cycle after the push.
REQ-008 A pipe request SHALL be valid only when pipe_we=1 and pipe_rd!=0.
REQ-009 FSM states SHALL be IDLE (FIFO empty), DRAIN (FIFO non-empty), and FORCE.
REQ-010 In IDLE and DRAIN, a valid pipe request SHALL win: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_wdata, and the FIFO head SHALL be held.
REQ-011 In DRAIN with no valid pipe request, the FIFO head SHALL be written with rf_we=(head_rd!=0) and popped the same cycle.
REQ-012 A head with rd=0 SHALL be popped without a write.
REQ-013 wait_cnt SHALL increment each DRAIN cycle in which the head is not popped, saturating at STARVE_LIMIT.
- wait_cnt SHALL clear on every pop and in IDLE.
REQ-014 When wait_cnt reaches STARVE_LIMIT, the next state SHALL be FORCE.
REQ-015 In FORCE, stall_req SHALL be 1 (combinational on state), the head SHALL be written and popped regardless of pipe_we, and the pipe request SHALL be ignored.
- The pipeline retries the pipe request the following cycle because MEM/WB is held.
REQ-016 FORCE SHALL last exactly one cycle.
- Next state SHALL be DRAIN if entries remain after the pop (including a same-cycle push), else IDLE.
REQ-017 stall_req SHALL be 0 in IDLE and DRAIN.
REQ-018 Transitions:
- IDLE->DRAIN on push.
- DRAIN->IDLE when the count becomes 0.
- Simultaneous push and pop SHALL keep the count unchanged.
REQ-019 rf_we, rf_waddr and rf_wdata SHALL be combinational; when rf_we=0, rf_waddr and rf_wdata SHALL be 0.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH, and entries SHALL be written in push order.
REQ-021 Ordering hazards between LU and pipe writes to the same rd are out of scope; the issue scoreboard prevents them.

Reset
REQ-022 While rstn=0, the block SHALL force:
- count=0, pointers=0, wait_cnt=0, state=IDLE;
- rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, buf_level=0;
- lu_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard all buffered entries without issuing writes.
REQ-024 The first push SHALL be accepted on the first clock edge after rstn rises.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Idle pass-through: pipe_we=1, rd=5, data=0xA5 -> same-cycle rf_we=1, waddr=5, wdata=0xA5, stall_req=0.
- LU into a free slot: push rd=7, data=0x11 with pipe_we=0 -> next cycle rf_we=1, waddr=7, buf_level 1->0.
- Starvation: push rd=3 with pipe requests every cycle -> 4 cycles of pipe writes, then a FORCE cycle with stall_req=1, waddr=3, then the pipe write resumes.
- Full: 2 pushes while blocked -> lu_ready=0, a third lu_valid is not accepted, and lu_ready=1 only the cycle after the count drops to 1.
- x0 drop: push rd=0 with the pipe idle -> pop with rf_we=0 and buf_level decrement.
- Reset mid-DRAIN with 2 entries -> buf_level=0, rf_we=0, no writes after release.
